// File: rtl/mem_wr_demux4_pkg.sv
// Shared types and constants for the four-bank byte write demultiplexer.
package mem_wr_demux4_pkg;
  localparam int NUM_BANKS = 4;
  localparam int BYTE_W    = 8;
  localparam int SEL_W     = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Even-parity bit: set when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/mem_wr_demux4_demux1x4.sv
// Decodes a bank index plus enable into a one-hot write strobe.
module demux1x4
  import mem_wr_demux4_pkg::*;
(
  input  logic                 en,
  input  logic [SEL_W-1:0]     sel,
  output logic [NUM_BANKS-1:0] onehot
);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_dec
    assign onehot[gi] = en && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/mem_wr_demux4.sv
// Four-bank byte write demultiplexer with a four-phase req/ack handshake.
// Optional per-bank even parity outputs when WR_PARITY_EN is defined.
module mem_wr_demux4
  import mem_wr_demux4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [SEL_W-1:0]     wr_sel,
  input  logic [BYTE_W-1:0]    wr_data,
  output logic                 wr_ack,
  output logic                 busy,
  output logic [NUM_BANKS-1:0] bank_we,
  output logic [BYTE_W-1:0]    bank0,
  output logic [BYTE_W-1:0]    bank1,
  output logic [BYTE_W-1:0]    bank2,
  output logic [BYTE_W-1:0]    bank3
`ifdef WR_PARITY_EN
  ,
  output logic [NUM_BANKS-1:0] bank_par
`endif
);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [BYTE_W-1:0]    data_q, data_d;
  logic [NUM_BANKS-1:0] bank_we_q, bank_we_d;
  logic                 wr_ack_q, wr_ack_d;
  logic                 busy_q, busy_d;
  logic [BYTE_W-1:0]    bank_q [NUM_BANKS];
  logic [BYTE_W-1:0]    bank_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] dec_onehot;
  logic                 dec_en;

  // Strobe is decoded from the live request so it is registered into WRITE.
  assign dec_en = (state_q == IDLE) && wr_req;

  demux1x4 u_demux (
    .en     (dec_en),
    .sel    (wr_sel),
    .onehot (dec_onehot)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    bank_we_d = '0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d   = WRITE;
          sel_d     = wr_sel;
          data_d    = wr_data;
          bank_we_d = dec_onehot;
        end
      end
      WRITE:   state_d = ACK;
      ACK:     if (!wr_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    wr_ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      data_q    <= '0;
      bank_we_q <= '0;
      wr_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      bank_we_q <= bank_we_d;
      wr_ack_q  <= wr_ack_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    always_comb begin
      bank_d[gi] = bank_q[gi];
      if (state_q == WRITE && sel_q == SEL_W'(gi)) bank_d[gi] = data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bank_q[gi] <= '0;
      else        bank_q[gi] <= bank_d[gi];
    end
  end

`ifdef WR_PARITY_EN
  logic [NUM_BANKS-1:0] par_q, par_d;

  // Parity tracks the byte: it is captured on the same edge as the bank write.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_par
    always_comb begin
      par_d[gi] = par_q[gi];
      if (state_q == WRITE && sel_q == SEL_W'(gi)) par_d[gi] = even_parity(data_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= '0;
    else        par_q <= par_d;
  end

  assign bank_par = par_q;
`endif

  assign wr_ack  = wr_ack_q;
  assign busy    = busy_q;
  assign bank_we = bank_we_q;
  assign bank0   = bank_q[0];
  assign bank1   = bank_q[1];
  assign bank2   = bank_q[2];
  assign bank3   = bank_q[3];

endmodule

// File: tb/tb_mem_wr_demux4.sv
// Self-checking bench for mem_wr_demux4; define WR_PARITY_EN to also check bank_par.
module tb_mem_wr_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       busy;
  logic [3:0] bank_we;
  logic [7:0] bank0, bank1, bank2, bank3;
`ifdef WR_PARITY_EN
  logic [3:0] bank_par;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_cnt    = 0;

  logic [7:0] model_bank [4];
  logic [7:0] dut_bank   [4];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  always_comb begin
    dut_bank[0] = bank0;
    dut_bank[1] = bank1;
    dut_bank[2] = bank2;
    dut_bank[3] = bank3;
  end

  mem_wr_demux4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_req  (wr_req),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .busy    (busy),
    .bank_we (bank_we),
    .bank0   (bank0),
    .bank1   (bank1),
    .bank2   (bank2),
    .bank3   (bank3)
`ifdef WR_PARITY_EN
    ,
    .bank_par(bank_par)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // One full handshake starting at a negedge; checks every phase against the model.
  task automatic run_write(input logic [1:0] sel, input logic [7:0] data,
                           input int hold, input bit drop_early, input bit scramble);
    logic [3:0] exp_we;
    int start_cyc;
    exp_we    = 4'b0001 << sel;
    start_cyc = cycle_cnt;
    wr_req  = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    @(negedge clk);
    tests_run++;
    if (bank_we !== exp_we || busy !== 1'b1 || wr_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_phase: bank_we=%b busy=%b ack=%b, expected bank_we=%b busy=1 ack=0",
               bank_we, busy, wr_ack, exp_we);
    end
    tests_run++;
    if (dut_bank[sel] !== model_bank[sel]) begin
      tests_failed++;
      $display("FAIL early_update: bank%0d=%h before commit, expected %h",
               sel, dut_bank[sel], model_bank[sel]);
    end
    if (scramble) begin
      wr_sel  = ~sel;
      wr_data = ~data;
    end
    if (drop_early) wr_req = 1'b0;
    @(negedge clk);
    model_bank[sel] = data;
    tests_run++;
    if (bank_we !== 4'b0000 || wr_ack !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_phase: bank_we=%b ack=%b busy=%b, expected bank_we=0000 ack=1 busy=1",
               bank_we, wr_ack, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (dut_bank[i] !== model_bank[i]) begin
        tests_failed++;
        $display("FAIL bank_value: bank%0d=%h expected %h", i, dut_bank[i], model_bank[i]);
      end
`ifdef WR_PARITY_EN
      tests_run++;
      if (bank_par[i] !== ^model_bank[i]) begin
        tests_failed++;
        $display("FAIL bank_par: bank_par[%0d]=%b expected %b", i, bank_par[i], ^model_bank[i]);
      end
`endif
    end
    if (!drop_early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        tests_run++;
        if (wr_ack !== 1'b1 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL ack_hold: ack=%b busy=%b while req held, expected 1/1", wr_ack, busy);
        end
      end
      wr_req = 1'b0;
    end
    @(negedge clk);
    tests_run++;
    if (wr_ack !== 1'b0 || busy !== 1'b0 || bank_we !== 4'b0000) begin
      tests_failed++;
      $display("FAIL return_idle: ack=%b busy=%b bank_we=%b, expected 0/0/0000",
               wr_ack, busy, bank_we);
    end
    $display("[TB] write bank%0d data=%h hold=%0d drop=%0d cycles=%0d",
             sel, data, hold, drop_early, cycle_cnt - start_cyc);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    wr_req  = 1'b0;
    wr_sel  = 2'd0;
    wr_data = 8'h00;
    for (int i = 0; i < 4; i++) model_bank[i] = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if (wr_ack !== 1'b0 || busy !== 1'b0 || bank_we !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ack=%b busy=%b bank_we=%b, expected 0/0/0000", wr_ack, busy, bank_we);
    end
    rst_n = 1'b1;
    // A write straight after release must be taken at the first rising edge.
    run_write(2'd0, 8'h5C, 0, 1'b0, 1'b0);
    run_write(2'd3, 8'hC3, 0, 1'b0, 1'b0);
    // Mid-cycle asynchronous reset: no clock edge between assertion and check.
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_bank[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (dut_bank[i] !== 8'h00) begin
        tests_failed++;
        $display("FAIL async_reset_bank: bank%0d=%h expected 00", i, dut_bank[i]);
      end
    end
    tests_run++;
    if (wr_ack !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_ctrl: ack=%b busy=%b expected 0/0", wr_ack, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    run_write(2'd2, 8'hA5, 1, 1'b0, 1'b0);
    tests_run++;
    if (bank2 !== 8'hA5 || bank0 !== 8'h00 || bank1 !== 8'h00 || bank3 !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_write: banks=%h %h %h %h expected 00 00 a5 00", bank0, bank1, bank2, bank3);
    end
  endtask

  task automatic test_sequential_fill();
    int t0;
    for (int i = 0; i < 4; i++) begin
      t0 = cycle_cnt;
      run_write(2'(i), 8'(8'h11 * (i + 1)), 0, 1'b0, 1'b0);
      tests_run++;
      if (cycle_cnt - t0 != 3) begin
        tests_failed++;
        $display("FAIL fill_period: txn %0d took %0d cycles, expected 3", i, cycle_cnt - t0);
      end
    end
    tests_run++;
    if (bank0 !== 8'h11 || bank1 !== 8'h22 || bank2 !== 8'h33 || bank3 !== 8'h44) begin
      tests_failed++;
      $display("FAIL fill_result: banks=%h %h %h %h expected 11 22 33 44", bank0, bank1, bank2, bank3);
    end
  endtask

  task automatic test_data_change();
    run_write(2'd1, 8'h0F, 0, 1'b0, 1'b1);
    tests_run++;
    if (bank1 !== 8'h0F) begin
      tests_failed++;
      $display("FAIL data_change: bank1=%h expected 0f", bank1);
    end
  endtask

  task automatic test_drop_in_write();
    run_write(2'd0, 8'h3C, 0, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    wr_req  = 1'b1;
    wr_sel  = 2'd1;
    wr_data = 8'h77;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || bank_we !== 4'b0010) begin
      tests_failed++;
      $display("FAIL abort_setup: busy=%b bank_we=%b expected 1/0010", busy, bank_we);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_bank[i] = 8'h00;
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (bank1 !== 8'h00 || wr_ack !== 1'b0 || busy !== 1'b0 || bank_we !== 4'b0000) begin
        tests_failed++;
        $display("FAIL abort: bank1=%h ack=%b busy=%b bank_we=%b expected 00/0/0/0000",
                 bank1, wr_ack, busy, bank_we);
      end
    end
  endtask

`ifdef WR_PARITY_EN
  task automatic test_parity();
    run_write(2'd3, 8'h07, 0, 1'b0, 1'b0);
    tests_run++;
    if (bank_par[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_07: bank_par[3]=%b expected 1", bank_par[3]);
    end
    run_write(2'd3, 8'h03, 0, 1'b0, 1'b0);
    tests_run++;
    if (bank_par[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_03: bank_par[3]=%b expected 0", bank_par[3]);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_write(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || wr_ack !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle_gap: busy=%b ack=%b expected 0/0", busy, wr_ack);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_sequential_fill();
    test_data_change();
    test_drop_in_write();
    test_abort();
`ifdef WR_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
